// File: rtl/store_outstanding_tracker.sv
// Tracks stores in flight to the AXI data port until their write responses return.
// Bounds outstanding stores, serialises uncached stores and reports erroring responses.
module store_outstanding_tracker #(
  parameter int unsigned          MaxOutstandingStores = 7,
  parameter int unsigned          AddrWidth            = 64,
  parameter logic [AddrWidth-1:0] CachedBase           = AddrWidth'(64'h8000_0000),
  parameter logic [AddrWidth-1:0] CachedLength         = AddrWidth'(64'h4000_0000),
  parameter int unsigned          CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 st_valid_i,
  input  logic [AddrWidth-1:0] st_addr_i,
  output logic                 st_ready_o,
  output logic                 axi_st_valid_o,
  input  logic                 axi_st_ready_i,
  input  logic                 b_valid_i,
  input  logic [1:0]           b_resp_i,
  output logic                 b_ready_o,
  output logic [CntWidth-1:0]  outstanding_cnt_o,
  output logic                 no_st_pending_o,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 spurious_o
);

  localparam int unsigned PtrWidth = (MaxOutstandingStores > 1) ? $clog2(MaxOutstandingStores) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstandingStores - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstandingStores);
  // One extra bit so base + length cannot wrap around the address space.
  localparam logic [AddrWidth:0] RegionLo = {1'b0, CachedBase};
  localparam logic [AddrWidth:0] RegionHi = {1'b0, CachedBase} + {1'b0, CachedLength};

  logic [AddrWidth-1:0]            addr_q [MaxOutstandingStores];
  logic [MaxOutstandingStores-1:0] uc_q;
  logic [PtrWidth-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]             cnt_q, cnt_d;
  logic                            uc_pending_q;
  logic                            empty_q;
  logic                            err_valid_q;
  logic [AddrWidth-1:0]            err_addr_q;
  logic                            spurious_q;

  logic st_uc;
  logic full;
  logic empty;
  logic allow;
  logic push;
  logic pop;
  logic spurious_hit;
  logic err_hit;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign st_uc = ({1'b0, st_addr_i} < RegionLo) || ({1'b0, st_addr_i} >= RegionHi);
  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);

  // Gate uses registered state only; a response this cycle never frees a slot this cycle.
  assign allow = !full && !uc_pending_q && (!st_uc || empty);

  assign axi_st_valid_o = st_valid_i && allow;
  assign st_ready_o     = axi_st_ready_i && allow;
  assign b_ready_o      = 1'b1;

  assign push         = st_valid_i && st_ready_o;
  assign pop          = b_valid_i && !empty;
  assign spurious_hit = b_valid_i && empty;
  assign err_hit      = pop && b_resp_i[1];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Entry payload carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr_i;
      uc_q[wr_ptr_q]   <= st_uc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
    end
  end

  // A uc store only enters an empty tracker, so while pending it is always the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      uc_pending_q <= 1'b0;
    end else begin
      uc_pending_q <= (uc_pending_q && !(pop && uc_q[rd_ptr_q])) || (push && st_uc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      spurious_q  <= 1'b0;
    end else begin
      err_valid_q <= err_hit;
      if (err_hit) err_addr_q <= addr_q[rd_ptr_q];
      spurious_q  <= spurious_q || spurious_hit;
    end
  end

  assign outstanding_cnt_o = cnt_q;
  assign no_st_pending_o   = empty_q;
  assign err_valid_o       = err_valid_q;
  assign err_addr_o        = err_addr_q;
  assign spurious_o        = spurious_q;

endmodule
